// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one imem read at a time, buffers returned words
// with their PCs, and presents the head entry toward IF/ID with redirect/kill handling.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [63:0] PC_out,
    output logic [31:0] Instruction
);

    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t                 state_q, state_d;
    logic [63:0]            fetch_pc_q, fetch_pc_d;
    logic [63:0]            req_pc_q, req_pc_d;
    logic                   kill_q, kill_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    entry_t [DEPTH-1:0]     fifo_q, fifo_d;
    entry_t                 last_q, last_d;
    entry_t                 head;
    logic                   push, pop;

    assign head          = fifo_q[rd_ptr_q];
    assign imem_req_addr = fetch_pc_q;
    // An empty buffer keeps showing the last instruction handed to decode.
    assign PC_out        = (count_q != '0) ? head.pc    : last_q.pc;
    assign Instruction   = (count_q != '0) ? head.instr : last_q.instr;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        kill_d         = kill_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_d         = fifo_q;
        last_d         = last_q;
        push           = 1'b0;
        imem_req_valid = 1'b0;

        fetch_valid = reset && (count_q != '0) && !redirect_valid;
        pop         = fetch_valid && !stall;

        case (state_q)
            S_REQ: begin
                imem_req_valid = reset && (count_q < DEPTH_C) && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    push = !kill_q && !redirect_valid;
                    if (push) begin
                        fetch_pc_d = req_pc_q + 64'd4;
                    end
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = {req_pc_q, imem_resp_data};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            last_d   = head;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A redirect flushes everything; an unanswered request must be drained as killed.
        if (redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc & ~64'h3;
            if (state_q == S_WAIT && !imem_resp_valid) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_q     <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table plus wrap and stall-hold sequences.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        fetch_valid;
    logic [63:0] PC_out;
    logic [31:0] Instruction;

    instr_fetch_unit #(.RESET_PC(64'h1000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .fetch_valid     (fetch_valid),
        .PC_out          (PC_out),
        .Instruction     (Instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdv;
        logic [63:0] rpc;
        logic        rdy;
        int          lat;
        logic        ev;
        logic [63:0] ea;
        logic        fv;
        logic [63:0] pc;
        logic [31:0] ins;
    } vec_t;

    localparam int NV = 37;
    vec_t tbl [NV];

    int n_tests = 0;
    int n_fail  = 0;

    // memory model state
    int          cur_lat;
    logic        acc;
    logic [63:0] acc_addr;
    logic        rst_s;
    logic        pending;
    int          cnt;
    logic [63:0] pend_addr;

    function automatic logic [31:0] w(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rst, stl, rdv, input logic [63:0] rpc,
                                input logic rdy, input int lat, input logic ev,
                                input logic [63:0] ea, input logic fv,
                                input logic [63:0] pc, input logic [31:0] ins);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy; v.lat = lat;
        v.ev = ev; v.ea = ea; v.fv = fv; v.pc = pc; v.ins = ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [63:0] rp,
                         input logic rdy, input int l);
        reset          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_req_ready = rdy;
        cur_lat        = l;
        #1;
    endtask

    // Advance one clock; the memory answers 'lat' cycles after an accepted request.
    task automatic advance();
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rst_s    = reset;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (!rst_s) begin
            pending = 1'b0;
        end else begin
            if (acc) begin
                pending   = 1'b1;
                cnt       = cur_lat;
                pend_addr = acc_addr;
            end
            if (pending) begin
                if (cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = w(pend_addr);
                    pending         = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    initial begin
        logic        got;
        logic        prev_fv, prev_stl;
        logic [63:0] prev_pc, exp_pc;
        logic        s;
        int          n_pop;

        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pending         = 1'b0;
        cnt             = 0;
        pend_addr       = '0;

        // rst stl rdv rpc rdy lat | req_valid req_addr fetch_valid PC_out Instruction
        tbl[0]  = mk(0,0,0,0,1,1, 0,64'h1000,0,64'h0,32'h0);
        tbl[1]  = mk(1,0,0,0,1,1, 1,64'h1000,0,64'h0,32'h0);
        tbl[2]  = mk(1,0,0,0,1,1, 0,64'h1000,0,64'h0,32'h0);
        tbl[3]  = mk(1,0,0,0,1,1, 1,64'h1004,1,64'h1000,w(64'h1000));
        tbl[4]  = mk(1,0,0,0,1,1, 0,64'h1004,0,64'h1000,w(64'h1000));
        tbl[5]  = mk(1,0,0,0,1,1, 1,64'h1008,1,64'h1004,w(64'h1004));
        tbl[6]  = mk(1,0,0,0,1,1, 0,64'h1008,0,64'h1004,w(64'h1004));
        tbl[7]  = mk(1,0,0,0,1,1, 1,64'h100C,1,64'h1008,w(64'h1008));
        tbl[8]  = mk(1,0,0,0,1,1, 0,64'h100C,0,64'h1008,w(64'h1008));
        tbl[9]  = mk(0,0,0,0,1,1, 0,64'h1010,0,64'h100C,w(64'h100C));
        tbl[10] = mk(0,0,0,0,1,1, 0,64'h1000,0,64'h0,32'h0);
        // back-pressure: stall six cycles, buffer fills, requests stop
        tbl[11] = mk(1,1,0,0,1,1, 1,64'h1000,0,64'h0,32'h0);
        tbl[12] = mk(1,1,0,0,1,1, 0,64'h1000,0,64'h0,32'h0);
        tbl[13] = mk(1,1,0,0,1,1, 1,64'h1004,1,64'h1000,w(64'h1000));
        tbl[14] = mk(1,1,0,0,1,1, 0,64'h1004,1,64'h1000,w(64'h1000));
        tbl[15] = mk(1,1,0,0,1,1, 0,64'h1008,1,64'h1000,w(64'h1000));
        tbl[16] = mk(1,1,0,0,1,1, 0,64'h1008,1,64'h1000,w(64'h1000));
        tbl[17] = mk(1,0,0,0,1,1, 0,64'h1008,1,64'h1000,w(64'h1000));
        tbl[18] = mk(1,0,0,0,1,1, 1,64'h1008,1,64'h1004,w(64'h1004));
        tbl[19] = mk(1,0,0,0,1,1, 0,64'h1008,0,64'h1004,w(64'h1004));
        // redirect while waiting on a slow response
        tbl[20] = mk(1,0,0,0,1,4, 1,64'h100C,1,64'h1008,w(64'h1008));
        tbl[21] = mk(1,0,1,64'h2002,1,1, 0,64'h100C,0,64'h1008,w(64'h1008));
        tbl[22] = mk(1,0,0,0,1,1, 0,64'h2000,0,64'h1008,w(64'h1008));
        tbl[23] = mk(1,0,0,0,1,1, 0,64'h2000,0,64'h1008,w(64'h1008));
        tbl[24] = mk(1,0,0,0,1,1, 0,64'h2000,0,64'h1008,w(64'h1008));
        tbl[25] = mk(1,0,0,0,1,1, 1,64'h2000,0,64'h1008,w(64'h1008));
        tbl[26] = mk(1,0,0,0,1,1, 0,64'h2000,0,64'h1008,w(64'h1008));
        // redirect coincident with a response while the buffer holds an entry
        tbl[27] = mk(1,1,0,0,1,1, 1,64'h2004,1,64'h2000,w(64'h2000));
        tbl[28] = mk(1,0,1,64'h3000,1,1, 0,64'h2004,0,64'h2000,w(64'h2000));
        tbl[29] = mk(1,0,0,0,1,1, 1,64'h3000,0,64'h1008,w(64'h1008));
        tbl[30] = mk(1,0,0,0,1,1, 0,64'h3000,0,64'h1008,w(64'h1008));
        // reset while a request is outstanding
        tbl[31] = mk(1,1,0,0,1,3, 1,64'h3004,1,64'h3000,w(64'h3000));
        tbl[32] = mk(1,1,0,0,1,1, 0,64'h3004,1,64'h3000,w(64'h3000));
        tbl[33] = mk(0,1,0,0,1,1, 0,64'h3004,0,64'h3000,w(64'h3000));
        tbl[34] = mk(0,0,0,0,1,1, 0,64'h1000,0,64'h0,32'h0);
        tbl[35] = mk(1,0,0,0,0,1, 1,64'h1000,0,64'h0,32'h0);
        tbl[36] = mk(1,0,0,0,0,1, 1,64'h1000,0,64'h0,32'h0);

        drive(0, 0, 0, '0, 0, 1);
        advance();
        advance();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rdv, tbl[i].rpc, tbl[i].rdy, tbl[i].lat);
            chk($sformatf("row%0d.req_valid", i),   {63'b0, imem_req_valid}, {63'b0, tbl[i].ev});
            chk($sformatf("row%0d.req_addr", i),    imem_req_addr,           tbl[i].ea);
            chk($sformatf("row%0d.fetch_valid", i), {63'b0, fetch_valid},    {63'b0, tbl[i].fv});
            chk($sformatf("row%0d.pc_out", i),      PC_out,                  tbl[i].pc);
            chk($sformatf("row%0d.instr", i),       {32'b0, Instruction},    {32'b0, tbl[i].ins});
            advance();
        end

        // wrap: low bits of the target are dropped, then PC rolls over to zero
        drive(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 2);
        chk("wrap.redirect_no_req", {63'b0, imem_req_valid}, 64'd0);
        advance();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1, 0, 0, '0, 1, 2);
            if (i == 0) chk("wrap.req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
            if (fetch_valid) begin
                got = 1'b1;
                chk("wrap.pc_top", PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("wrap.instr_top", {32'b0, Instruction}, {32'b0, w(64'hFFFF_FFFF_FFFF_FFFC)});
            end
            advance();
        end
        if (!got) chk("wrap.timeout_top", 64'd0, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1, 0, 0, '0, 1, 2);
            if (fetch_valid) begin
                got = 1'b1;
                chk("wrap.pc_zero", PC_out, 64'h0);
                chk("wrap.instr_zero", {32'b0, Instruction}, {32'b0, w(64'h0)});
            end
            advance();
        end
        if (!got) chk("wrap.timeout_zero", 64'd0, 64'd1);

        // stall pattern with varying latency: head must hold, pops must be in order
        exp_pc   = 64'h4;
        prev_fv  = 1'b0;
        prev_stl = 1'b0;
        prev_pc  = '0;
        n_pop    = 0;
        for (int i = 0; i < 40; i++) begin
            s = ((i % 5) < 2);
            drive(1, s, 0, '0, 1, 1 + (i % 3));
            if (prev_fv && prev_stl) begin
                chk($sformatf("hold%0d.fetch_valid", i), {63'b0, fetch_valid}, 64'd1);
                chk($sformatf("hold%0d.pc_out", i), PC_out, prev_pc);
            end
            if (fetch_valid && !s) begin
                chk($sformatf("pop%0d.pc_out", n_pop), PC_out, exp_pc);
                chk($sformatf("pop%0d.instr", n_pop), {32'b0, Instruction}, {32'b0, w(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                n_pop++;
            end
            prev_fv  = fetch_valid;
            prev_stl = s;
            prev_pc  = PC_out;
            advance();
        end
        chk("stream.min_pops", {63'b0, n_pop >= 5}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
